// File: rtl/mips_pkg.sv
// mips_pkg: shared vectors and architectural constants for the MIPS core
package mips_pkg;
  localparam logic [31:0] RESET_VEC      = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC        = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC        = 32'h8000_0008;
  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam int          SUPERVISOR_BIT = 31;
  localparam int          REG_K0         = 26;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: next-PC priority mux, supervisor-bit masking and EPC selection
module if_next_pc
  import mips_pkg::SUPERVISOR_BIT;
#(
  parameter logic [31:0] IRQ_VEC = mips_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC = mips_pkg::EXC_VEC
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] ifid_pc_i,
  input  logic [31:0] ifid_pc4_i,
  input  logic        ifid_valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  input  logic        exc_i,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc4_o,
  output logic [31:0] epc_d_o,
  output logic        take_o,
  output logic        bubble_o,
  output logic        hold_o
);
  logic [31:0] tgt;
  logic        exc_take, irq_take;
  always_comb begin
    pc4_o    = {pc_i[SUPERVISOR_BIT], pc_i[30:0] + 31'd4};
    // a redirect can drop the supervisor bit but never raise it
    tgt      = {redirect_pc_i[SUPERVISOR_BIT] & pc_i[SUPERVISOR_BIT], redirect_pc_i[30:0]};
    exc_take = exc_i & ifid_valid_i;
    irq_take = irq_i & ~pc_i[SUPERVISOR_BIT] & ~ifid_pc_i[SUPERVISOR_BIT] & ~exc_take;
    take_o   = exc_take | irq_take;
    bubble_o = take_o | redirect_i | flush_i;
    hold_o   = stall_i & ~bubble_o;
    pc_d_o   = exc_take ? EXC_VEC : irq_take ? IRQ_VEC : redirect_i ? tgt : stall_i ? pc_i : pc4_o;
    epc_d_o  = exc_take ? ifid_pc4_i : redirect_i ? tgt : ifid_valid_i ? ifid_pc_i : pc_i;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch, owns PC and the IF/ID pipeline register
module if_stage
  import mips_pkg::NOP, mips_pkg::SUPERVISOR_BIT;
#(
  parameter logic [31:0] RESET_VEC = mips_pkg::RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = mips_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC   = mips_pkg::EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  input  logic        exc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] epc_o,
  output logic        epc_we_o,
  output logic        supervisor_o
);
  logic [31:0] pc_q, pc_d, pc4, instr_q, ipc_q, ipc4_q, epc_q, epc_d;
  logic        valid_q, epc_we_q, take, bubble, hold;
  if_next_pc #(.IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) u_next (
    .pc_i(pc_q), .ifid_pc_i(ipc_q), .ifid_pc4_i(ipc4_q), .ifid_valid_i(valid_q),
    .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .irq_i(irq_i), .exc_i(exc_i),
    .pc_d_o(pc_d), .pc4_o(pc4), .epc_d_o(epc_d), .take_o(take),
    .bubble_o(bubble), .hold_o(hold)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      instr_q  <= NOP;
      ipc_q    <= '0;
      ipc4_q   <= '0;
      valid_q  <= 1'b0;
      epc_q    <= '0;
      epc_we_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      epc_we_q <= take;
      if (take) epc_q <= epc_d;
      if (!hold) begin
        instr_q <= bubble ? NOP : imem_data_i;
        valid_q <= ~bubble;
        // a bubble keeps the old pc/pc4 so supervisor masking still sees them
        if (!bubble) begin
          ipc_q  <= pc_q;
          ipc4_q <= pc4;
        end
      end
    end
  end
  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc_o    = ipc_q;
  assign ifid_pc4_o   = ipc4_q;
  assign ifid_valid_o = valid_q;
  assign epc_o        = epc_q;
  assign epc_we_o     = epc_we_q;
  assign supervisor_o = pc_q[SUPERVISOR_BIT];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plan plus randomized traffic against a behavioural fetch model
module tb_if_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0, irq = 1'b0, exc = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc, ifid_pc4, epc;
  logic        ifid_valid, epc_we, supervisor;
  int          tests = 0, fails = 0;

  logic [31:0] m_pc = 32'h8000_0000, m_ins = '0, m_ipc = '0, m_ipc4 = '0, m_epc = '0;
  logic        m_val = 1'b0, m_we = 1'b0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]} + 32'd1;
  endfunction

  assign imem_data = rom(imem_addr);

  if_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush), .redirect_i(redirect),
    .redirect_pc_i(rpc), .irq_i(irq), .exc_i(exc), .imem_addr_o(imem_addr),
    .imem_data_i(imem_data), .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc),
    .ifid_pc4_o(ifid_pc4), .ifid_valid_o(ifid_valid), .epc_o(epc), .epc_we_o(epc_we),
    .supervisor_o(supervisor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", imem_addr, m_pc);
    chk("supervisor", {31'd0, supervisor}, {31'd0, m_pc[31]});
    chk("ifid_instr", ifid_instr, m_ins);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc4", ifid_pc4, m_ipc4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_val});
    chk("epc_we", {31'd0, epc_we}, {31'd0, m_we});
    chk("epc", epc, m_epc);
  endtask

  task automatic bubble_ifid();
    m_ins = 32'h0;
    m_val = 1'b0;
  endtask

  // one clock: evaluate the fetch rules on the model, then compare after the edge
  task automatic step();
    logic [31:0] seq, tgt, fetched;
    seq     = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    tgt     = m_pc[31] ? rpc : (rpc & 32'h7FFF_FFFF);
    fetched = rom(m_pc);
    if (reset) begin
      m_pc = 32'h8000_0000; m_ins = 0; m_ipc = 0; m_ipc4 = 0; m_val = 0; m_we = 0; m_epc = 0;
    end else if (exc && m_val) begin
      m_epc = m_ipc4; m_we = 1; m_pc = 32'h8000_0008; bubble_ifid();
    end else if (irq && !m_pc[31] && !m_ipc[31]) begin
      if (redirect) m_epc = tgt;
      else if (m_val) m_epc = m_ipc;
      else m_epc = m_pc;
      m_we = 1; m_pc = 32'h8000_0004; bubble_ifid();
    end else begin
      m_we = 0;
      if (redirect) begin
        m_pc = tgt; bubble_ifid();
      end else if (stall) begin
        if (flush) bubble_ifid();
      end else begin
        if (flush) bubble_ifid();
        else begin m_ins = fetched; m_ipc = m_pc; m_ipc4 = seq; m_val = 1; end
        m_pc = seq;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    step(); step();
    chk("rst_pc", imem_addr, 32'h8000_0000);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    reset = 0;
    step(); chk("seq4", imem_addr, 32'h8000_0004); chk("valid_rise", {31'd0, ifid_valid}, 32'd1);
    step(); chk("seq8", imem_addr, 32'h8000_0008);
    step(); chk("seqC", imem_addr, 32'h8000_000C);
    redirect = 1; rpc = 32'h0000_0040; step();
    chk("redir_user", imem_addr, 32'h0000_0040);
    chk("redir_sup", {31'd0, supervisor}, 32'd0);
    chk("redir_bubble", ifid_instr, 32'h0);
    rpc = 32'h8000_0100; step(); chk("redir_mask", imem_addr, 32'h0000_0100);
    rpc = 32'h0000_000C; step(); redirect = 0; step();
    stall = 1; step(); step();
    chk("stall_pc", imem_addr, 32'h0000_0010); chk("stall_ifid", ifid_pc, 32'h0000_000C);
    stall = 0; step(); chk("after_stall", imem_addr, 32'h0000_0014);
    step(); step(); step(); chk("pre_irq_ifid", ifid_pc, 32'h0000_001C);
    irq = 1; step();
    chk("irq_pc", imem_addr, 32'h8000_0004); chk("irq_epc", epc, 32'h0000_001C);
    chk("irq_we", {31'd0, epc_we}, 32'd1);
    step(); chk("irq_we_once", {31'd0, epc_we}, 32'd0); chk("irq_masked", imem_addr, 32'h8000_0008);
    step(); irq = 0;
    redirect = 1; rpc = 32'h0000_002C; step(); redirect = 0; step(); step();
    exc = 1; irq = 1; step();
    chk("exc_pc", imem_addr, 32'h8000_0008); chk("exc_epc", epc, 32'h0000_0034);
    exc = 0; irq = 0; step();
    redirect = 1; rpc = 32'h0000_0040; step(); redirect = 0; step();
    irq = 1; redirect = 1; rpc = 32'h0000_0050; step();
    chk("irqred_pc", imem_addr, 32'h8000_0004); chk("irqred_epc", epc, 32'h0000_0050);
    irq = 0; redirect = 0; stall = 1; step(); step();
    reset = 1; step();
    chk("midstall_rst_pc", imem_addr, 32'h8000_0000);
    chk("midstall_rst_valid", {31'd0, ifid_valid}, 32'd0);
    reset = 0; stall = 0;
    for (int i = 0; i < 500; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 6) == 0);
      redirect = ($urandom_range(0, 4) == 0);
      irq      = ($urandom_range(0, 4) == 0);
      exc      = ($urandom_range(0, 6) == 0);
      rpc      = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc[30:0] = 31'h7FFF_FFFC;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
